fir_coeff_loader: RTL
=====================

# fir_coeff_loader

Coefficient writer for the 8-tap FIR datapath. Accepts coefficients as a serial valid/ready word stream, stages them in a shadow bank, checks frame length, and commits the whole set atomically to an active bank. The active bank drives the FIR filter's `filterCoeff` input, so the filter never sees a partially updated coefficient set.

## Interface
- `WIDTH`, 16, coefficient word width (signed, Q format)
- `TAPS`, 8, number of filter taps; must be ≥ 2
- `fractWidth`, 12, fractional bits; sets the reset identity value
- `clk`  input  1  single clock, rising edge
- `reset`  input  1  synchronous, active-high reset
- `s_valid`  input  1  coefficient word valid
- `s_ready`  output  1  loader can accept a word
- `s_data`  input  WIDTH  signed coefficient word, tap 0 first
- `s_last`  input  1  marks the final word of a frame
- `swap_en`  input  1  commit window (filter sample boundary)
- `coeff`  output  WIDTH × [0:TAPS-1]  active signed coefficients, registered
- `coeff_update`  output  1  one-cycle pulse on the edge the active bank changes
- `pending`  output  1  a valid frame is staged and waiting for `swap_en`
- `err`  output  1  one-cycle pulse when a frame has the wrong length

## Operation
- Handshake: a word transfers on an edge where `s_valid && s_ready`. `s_valid` may gap freely. Words carry no address; position comes from the internal count `cnt`.
- N = expected words per frame (TAPS, or see Configuration).
- States: IDLE, LOAD, DRAIN, PENDING.
  - IDLE: `s_ready`=1. On accept: write `shadow[0]`, `cnt`=1, go to LOAD. If `s_last` is set on that word: pulse `err`, stay in IDLE.
  - LOAD: `s_ready`=1. On accept: write `shadow[cnt]`.
    - `s_last && cnt==N-1`: go to PENDING.
    - `s_last && cnt<N-1`: pulse `err`, go to IDLE (frame too short).
    - `!s_last && cnt==N-1`: go to DRAIN.
    - Otherwise: `cnt++`.
  - DRAIN: `s_ready`=1. Accept and discard words until `s_last` is accepted, then pulse `err` and go to IDLE (frame too long).
  - PENDING: `s_ready`=0, `pending`=1. On an edge with `swap_en`=1: `coeff <= shadow`, pulse `coeff_update`, go to IDLE.
- A discarded frame (error or reset) leaves `coeff` untouched.
- Reset values:
  - state IDLE, `cnt`=0, shadow all 0.
  - `coeff[0]` = 1 << fractWidth (identity, 16'h1000 at defaults); `coeff[1..TAPS-1]` = 0.
  - `coeff_update`=0, `err`=0, `pending`=0.
- Reset mid-frame or in PENDING discards the staged frame and restores the identity `coeff`.

## Timing
- `s_ready` and `pending` are decoded from registered state only; there is no combinational path from `s_valid` to `s_ready`.
- The last word is accepted at edge t; `pending`=1 from t. `swap_en` sampled at t itself is ignored. The earliest commit is edge t+1.
- `coeff` and `coeff_update` change on the same edge; `coeff_update` is high for exactly one cycle.
- `err` is high for the one cycle after the edge that accepts the terminating `s_last`.
- Back-to-back frames: the next frame may start the cycle after the commit edge. Minimum frame period is N+1 cycles.

## Configuration
- `FIR_COEFF_SYMMETRIC_EN` defined:
  - N = (TAPS+1)/2.
  - On commit, `coeff[k]` and `coeff[TAPS-1-k]` both take `shadow[k]`, supporting linear-phase filters.
- Undefined: N = TAPS, and `coeff[k]` takes `shadow[k]` directly.
- Length checking, handshake and timing are identical in both builds, relative to N.

## Test plan
- Reset: `reset` high for 2 cycles → `coeff`={1000,0,0,0,0,0,0,0} (hex), `s_ready`=1, `err`=0, `pending`=0, `coeff_update`=0.
- Nominal load: 8 words 0x0100..0x0800 with `s_last` on the 8th and random `s_valid` gaps; hold `swap_en`=0 for 5 cycles, then 1 → `coeff` unchanged and `s_ready`=0 while pending; at the swap edge `coeff[k]`=0x0100·(k+1) and `coeff_update` pulses once.
- Short frame: 5 words, `s_last` on the 5th → `err` pulses once, `coeff` unchanged, `pending` never set, `s_ready`=1 on the next cycle.
- Long frame: 10 words, `s_last` on the 10th → `s_ready` stays 1 throughout, `err` pulses after the 10th word, `coeff` unchanged; a following valid 8-word frame commits normally.
- Reset mid-operation: `reset` after 4 words, and separately `reset` while in PENDING → identity `coeff`, no `coeff_update`; a subsequent full load commits correctly.
- Symmetric build (`FIR_COEFF_SYMMETRIC_EN`): words 0x0001, 0x0002, 0x0003, 0x0004 with `s_last` on the 4th, then `swap_en` → `coeff`={1,2,3,4,4,3,2,1}; a 5-word frame → `err` pulse, `coeff` unchanged.

Source files
------------

// File: rtl/fir_coeff_loader_if.sv
// ----------------------------------------------------------------------------
// fir_coeff_loader_if
//
// Serial coefficient word stream with a valid/ready handshake. A word moves
// on a rising edge where valid && ready are both high.
//
// Signals:
//   valid  source -> loader  word on data is valid
//   ready  loader -> source  loader can accept a word this cycle
//   data   source -> loader  signed coefficient word, tap 0 first
//   last   source -> loader  marks the final word of a frame
//
// Modports:
//   master  the word source
//   slave   the coefficient loader
// ----------------------------------------------------------------------------
interface fir_coeff_loader_if #(
    parameter int WIDTH = 16
);
    logic                    valid;
    logic                    ready;
    logic signed [WIDTH-1:0] data;
    logic                    last;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/fir_coeff_loader.sv
// ----------------------------------------------------------------------------
// fir_coeff_loader
//
// Coefficient writer for the FIR datapath. Words arrive on a valid/ready
// stream, are staged in a shadow bank, the frame length is checked against
// N, and a complete frame is committed atomically to the active bank on a
// cycle where swap_en is high. The active bank feeds the filter, so the
// filter never sees a partially written coefficient set.
//
// Optional build macro:
//   FIR_COEFF_SYMMETRIC_EN  frames carry N = (TAPS+1)/2 words; on commit
//                           coeff[k] and coeff[TAPS-1-k] both take shadow[k].
//                           Undefined: N = TAPS and coeff[k] takes shadow[k].
//
// Parameters:
//   WIDTH       coefficient word width (signed, Q format)
//   TAPS        number of filter taps (>= 2)
//   fractWidth  fractional bits; coeff[0] resets to 1.0 = 1 << fractWidth
//
// Ports:
//   clk           rising-edge clock
//   reset         synchronous active-high reset
//   s             word stream (slave side of fir_coeff_loader_if)
//   swap_en       commit window (filter sample boundary)
//   coeff         active signed coefficients, registered
//   coeff_update  one-cycle pulse on the edge the active bank changes
//   pending       a valid frame is staged and waiting for swap_en
//   err           one-cycle pulse after a frame of the wrong length
// ----------------------------------------------------------------------------
module fir_coeff_loader #(
    parameter int WIDTH      = 16,
    parameter int TAPS       = 8,
    parameter int fractWidth = 12
) (
    input  logic                    clk,
    input  logic                    reset,
    fir_coeff_loader_if.slave       s,
    input  logic                    swap_en,
    output logic signed [WIDTH-1:0] coeff [0:TAPS-1],
    output logic                    coeff_update,
    output logic                    pending,
    output logic                    err
);

`ifdef FIR_COEFF_SYMMETRIC_EN
    localparam int N = (TAPS + 1) / 2;
`else
    localparam int N = TAPS;
`endif

    localparam int                      CNT_W    = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0]        LAST_IDX = CNT_W'(N - 1);
    localparam logic signed [WIDTH-1:0] IDENT    = WIDTH'(1) << fractWidth;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DRAIN,
        ST_PENDING
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    err_q, err_d;
    logic                    upd_q, upd_d;
    logic                    wr_en;
    logic [CNT_W-1:0]        wr_idx;
    logic                    ready_int;

    logic signed [WIDTH-1:0] shadow_q     [0:N-1];
    logic signed [WIDTH-1:0] coeff_q      [0:TAPS-1];
    logic signed [WIDTH-1:0] commit_val   [0:TAPS-1];

    // ------------------------------------------------------------------
    // State register and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            upd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            upd_q   <= upd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (wr_en && (wr_idx == CNT_W'(i))) begin
                    shadow_q[i] <= s.data;
                end
            end
        end
    end

    // The active bank only moves on the commit edge, which is exactly the
    // edge that raises coeff_update.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < TAPS; i++) begin
                coeff_q[i] <= (i == 0) ? IDENT : '0;
            end
        end else if (upd_d) begin
            for (int i = 0; i < TAPS; i++) begin
                coeff_q[i] <= commit_val[i];
            end
        end
    end

    // Shadow-to-active routing: mirrored for the symmetric build.
    for (genvar gi = 0; gi < TAPS; gi++) begin : g_commit
`ifdef FIR_COEFF_SYMMETRIC_EN
        localparam int SRC = (gi < N) ? gi : (TAPS - 1 - gi);
`else
        localparam int SRC = gi;
`endif
        assign commit_val[gi] = shadow_q[SRC];
    end

    // ------------------------------------------------------------------
    // Next-state logic. Words are only accepted in states where ready is
    // high, so s.valid alone qualifies a transfer inside those states.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        upd_d   = 1'b0;
        wr_en   = 1'b0;
        wr_idx  = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (s.valid) begin
                    wr_en  = 1'b1;
                    wr_idx = '0;
                    if (s.last) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = ST_LOAD;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            ST_LOAD: begin
                if (s.valid) begin
                    wr_en = 1'b1;
                    if (cnt_q == LAST_IDX) begin
                        state_d = s.last ? ST_PENDING : ST_DRAIN;
                        cnt_d   = '0;
                    end else if (s.last) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
                // Overlong frame: swallow words until its last one.
                if (s.valid && s.last) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_PENDING: begin
                if (swap_en) begin
                    upd_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs decoded from registered state only
    // ------------------------------------------------------------------
    always_comb begin
        ready_int = 1'b1;
        pending   = 1'b0;
        if (state_q == ST_PENDING) begin
            ready_int = 1'b0;
            pending   = 1'b1;
        end
    end

    assign s.ready      = ready_int;
    assign coeff        = coeff_q;
    assign coeff_update = upd_q;
    assign err          = err_q;

endmodule
